mem_bus_arbiter: RTL

- Shares the single memory bus between the instruction-fetch port (imem) and the load/store port (dmem).
- Decodes each granted request by address to one of three slaves: bram, print or clint.
- Sits between the fetch buffer/store buffer and the memory-mapped slaves.
- One transaction outstanding at a time.
- Arbitration is round-robin on conflict.
- A watchdog terminates hung transactions.

---
 rtl/mem_bus_arbiter_if.sv | 50 +++++
 rtl/mem_bus_arbiter.sv | 117 +++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle around the arbiter. It covers the two requester ports
// (imem, dmem) and the three memory-mapped slaves (bram, print, clint).
// master: the arbiter's view. slave: the environment's view
// (the requesters and the slaves).
interface mem_bus_arbiter_if;
   // fetch port
   logic        imem_valid;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic        imem_error;
   // load/store port
   logic        dmem_valid;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic [3:0]  dmem_wstrb;
   logic        dmem_ready;
   logic [31:0] dmem_rdata;
   logic        dmem_error;
   // slave side
   logic        bram_valid, print_valid, clint_valid;
   logic        slv_instr;
   logic [31:0] slv_addr;
   logic [31:0] slv_wdata;
   logic [3:0]  slv_wstrb;
   logic        bram_ready, print_ready, clint_ready;
   logic [31:0] bram_rdata, print_rdata, clint_rdata;

   modport master (
      input  imem_valid, imem_addr,
      output imem_ready, imem_rdata, imem_error,
      input  dmem_valid, dmem_addr, dmem_wdata, dmem_wstrb,
      output dmem_ready, dmem_rdata, dmem_error,
      output bram_valid, print_valid, clint_valid,
      output slv_instr, slv_addr, slv_wdata, slv_wstrb,
      input  bram_ready, print_ready, clint_ready,
      input  bram_rdata, print_rdata, clint_rdata
   );

   modport slave (
      output imem_valid, imem_addr,
      input  imem_ready, imem_rdata, imem_error,
      output dmem_valid, dmem_addr, dmem_wdata, dmem_wstrb,
      input  dmem_ready, dmem_rdata, dmem_error,
      input  bram_valid, print_valid, clint_valid,
      input  slv_instr, slv_addr, slv_wdata, slv_wstrb,
      output bram_ready, print_ready, clint_ready,
      output bram_rdata, print_rdata, clint_rdata
   );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter between the fetch and load/store ports on a single
// memory bus. It allows one transaction in flight at a time. The granted
// request is registered and decoded to bram, print or clint. A 10-bit
// watchdog ends a WAIT that the selected slave never answers.
module mem_bus_arbiter #(
   parameter logic [31:0] bram_base_addr  = 32'h0000_0000,
   parameter logic [31:0] bram_top_addr   = 32'h0010_0000,
   parameter logic [31:0] print_base_addr = 32'h0100_0000,
   parameter logic [31:0] print_top_addr  = 32'h0100_0004,
   parameter logic [31:0] clint_base_addr = 32'h0200_0000,
   parameter logic [31:0] clint_top_addr  = 32'h0200_C000,
   parameter int          timeout_cycles  = 1023
) (
   input logic                clock,
   input logic                reset,
   mem_bus_arbiter_if.master  bus
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ISSUE = 2'd1;
   localparam logic [1:0] WAIT  = 2'd2;
   localparam logic [1:0] ERR   = 2'd3;
   localparam logic [9:0] WDOG_LIMIT = 10'(timeout_cycles);

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic        instr;
   } req_t;

   logic [1:0]  state;
   logic        rr_imem;      // 1: imem wins the next conflict
   req_t        req_q, gnt_req;
   logic [2:0]  sel_q, sel_dec; // one-hot {clint, print, bram}
   logic [9:0]  wdog;
   logic        gnt_any, gnt_imem;
   logic        sel_rdy, wait_done, wait_to, done, fail;
   logic [31:0] sel_rdata, rdata;

   function automatic logic in_win(input logic [31:0] a, input logic [31:0] lo,
                                   input logic [31:0] hi);
      return (a >= lo) && (a < hi);
   endfunction

   // Grant choice and address decode of the request that IDLE would accept.
   always_comb begin
      gnt_any       = bus.imem_valid | bus.dmem_valid;
      gnt_imem      = bus.imem_valid & (~bus.dmem_valid | rr_imem);
      gnt_req.instr = gnt_imem;
      gnt_req.addr  = gnt_imem ? bus.imem_addr : bus.dmem_addr;
      gnt_req.wdata = gnt_imem ? 32'h0 : bus.dmem_wdata;
      gnt_req.wstrb = gnt_imem ? 4'h0  : bus.dmem_wstrb;
      sel_dec[0]    = in_win(gnt_req.addr, bram_base_addr,  bram_top_addr);
      sel_dec[1]    = in_win(gnt_req.addr, print_base_addr, print_top_addr);
      sel_dec[2]    = in_win(gnt_req.addr, clint_base_addr, clint_top_addr);
   end

   // Completion detection. Readies from slaves that were not selected are masked out.
   always_comb begin
      sel_rdy   = |(sel_q & {bus.clint_ready, bus.print_ready, bus.bram_ready});
      sel_rdata = 32'h0;
      if (sel_q[0]) sel_rdata = bus.bram_rdata;
      if (sel_q[1]) sel_rdata = bus.print_rdata;
      if (sel_q[2]) sel_rdata = bus.clint_rdata;
      wait_done = (state == WAIT) & sel_rdy;
      wait_to   = (state == WAIT) & ~sel_rdy & (wdog == WDOG_LIMIT);
      done      = wait_done | wait_to | (state == ERR);
      fail      = wait_to | (state == ERR);
      rdata     = wait_done ? sel_rdata : 32'h0;
   end

   assign bus.imem_ready  = done & req_q.instr;
   assign bus.imem_error  = fail & req_q.instr;
   assign bus.imem_rdata  = req_q.instr ? rdata : 32'h0;
   assign bus.dmem_ready  = done & ~req_q.instr;
   assign bus.dmem_error  = fail & ~req_q.instr;
   assign bus.dmem_rdata  = req_q.instr ? 32'h0 : rdata;
   assign bus.bram_valid  = (state == ISSUE) & sel_q[0];
   assign bus.print_valid = (state == ISSUE) & sel_q[1];
   assign bus.clint_valid = (state == ISSUE) & sel_q[2];
   assign bus.slv_instr   = req_q.instr;
   assign bus.slv_addr    = req_q.addr;
   assign bus.slv_wdata   = req_q.wdata;
   assign bus.slv_wstrb   = req_q.wstrb;

   // Transaction FSM. It holds the grant, the round-robin pointer and the watchdog.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         rr_imem <= 1'b0;
         req_q   <= '0;
         sel_q   <= '0;
         wdog    <= '0;
      end else begin
         case (state)
            IDLE: if (gnt_any) begin
               req_q <= gnt_req;
               sel_q <= sel_dec;
               if (bus.imem_valid && bus.dmem_valid) rr_imem <= ~rr_imem;
               state <= (|sel_dec) ? ISSUE : ERR;
            end
            ISSUE: begin
               wdog  <= '0;
               state <= WAIT;
            end
            WAIT: begin
               if (sel_rdy || wdog == WDOG_LIMIT) state <= IDLE;
               else                               wdog  <= wdog + 10'd1;
            end
            ERR:     state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule
